// File: rtl/scan_chain_ctrl.sv
// ---------------------------------------------------------------------------
// scan_chain_ctrl
//   Drives one scan operation on an external mux-D scan chain:
//     LOAD    : shift the latched pattern in, LSB first (SE=1, SI=pat[k])
//     CAPTURE : one functional clock (SE=0), only when cap_en was latched high
//     UNLOAD  : shift the response out (SE=1, SI=0), resp[k] <= SO
//     DONE    : one-cycle done pulse, then back to IDLE
//   Every output is registered and changes together with the state.
//
// Ports
//   CK      in   clock, rising edge, shared with the scan chain
//   RN      in   asynchronous active-low reset
//   start   in   start request, only looked at in IDLE
//   cap_en  in   1 = load/capture/unload, 0 = loopback (load/unload)
//   abort   in   synchronous cancel of a running operation
//   pat     in   stimulus pattern, latched with start
//   SO      in   Q of the last chain flop (position CHAIN_LEN-1)
//   SE      out  scan enable to all chain flops
//   SI      out  scan input to chain flop 0
//   busy    out  high in every state except IDLE
//   done    out  single-cycle completion pulse
//   resp    out  unloaded response, held from done until the next start
// ---------------------------------------------------------------------------
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 16
) (
  input  logic                 CK,
  input  logic                 RN,
  input  logic                 start,
  input  logic                 cap_en,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pat,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] resp
);

  localparam int CNT_W = $clog2(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic                 cap_q, cap_d;
  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;
  logic                 se_q, se_d;
  logic                 si_q, si_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     cnt_inc;

  assign cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state and next-output logic; outputs default to the idle values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pat_d    = pat_q;
    cap_d    = cap_q;
    shadow_d = shadow_q;
    resp_d   = resp_q;
    se_d     = 1'b0;
    si_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    if (abort && (state_q != ST_IDLE)) begin
      // Cancel: partial shadow bits are simply never transferred to resp.
      state_d = ST_IDLE;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          // abort in IDLE outranks start, so the request is dropped.
          if (start && !abort) begin
            state_d = ST_LOAD;
            pat_d   = pat;
            cap_d   = cap_en;
            cnt_d   = {CNT_W{1'b0}};
            se_d    = 1'b1;
            si_d    = pat[0];
            busy_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end

        ST_LOAD: begin
          busy_d = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d = {CNT_W{1'b0}};
            if (cap_q) begin
              state_d = ST_CAPTURE;
              se_d    = 1'b0;
            end else begin
              state_d = ST_UNLOAD;
              se_d    = 1'b1;
            end
          end else begin
            // SI for the next LOAD cycle is the next pattern bit.
            cnt_d = cnt_inc;
            se_d  = 1'b1;
            si_d  = pat_q[cnt_inc];
          end
        end

        ST_CAPTURE: begin
          state_d = ST_UNLOAD;
          cnt_d   = {CNT_W{1'b0}};
          se_d    = 1'b1;
          busy_d  = 1'b1;
        end

        ST_UNLOAD: begin
          busy_d          = 1'b1;
          shadow_d[cnt_q] = SO;
          if (cnt_q == CNT_LAST) begin
            // The last bit lands on the same edge that enters DONE,
            // so resp takes the shadow including that bit.
            state_d = ST_DONE;
            cnt_d   = {CNT_W{1'b0}};
            resp_d  = shadow_d;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
            se_d  = 1'b1;
          end
        end

        ST_DONE: begin
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      pat_q    <= {CHAIN_LEN{1'b0}};
      cap_q    <= 1'b0;
      shadow_q <= {CHAIN_LEN{1'b0}};
      resp_q   <= {CHAIN_LEN{1'b0}};
      se_q     <= 1'b0;
      si_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      cap_q    <= cap_d;
      shadow_q <= shadow_d;
      resp_q   <= resp_d;
      se_q     <= se_d;
      si_q     <= si_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign SE   = se_q;
  assign SI   = si_q;
  assign busy = busy_q;
  assign done = done_q;
  assign resp = resp_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scan_chain_ctrl
//   Bench for scan_chain_ctrl with a behavioural mux-D scan chain attached.
//   Expected responses come from the chain's meaning: loopback returns the
//   pattern itself, capture returns the functional D vector bit-reversed
//   (flop CHAIN_LEN-1 leaves first). Latency and SE counts come from the
//   operation lengths.
// ---------------------------------------------------------------------------
module tb_scan_chain_ctrl;

  localparam int N = 16;

  logic         CK;
  logic         RN;
  logic         start;
  logic         cap_en;
  logic         abort;
  logic [N-1:0] pat;
  logic         SO;
  logic         SE;
  logic         SI;
  logic         busy;
  logic         done;
  logic [N-1:0] resp;

  logic [N-1:0] chain_q;
  logic [N-1:0] chain_d;

  int checks;
  int errors;

  scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
    .CK    (CK),
    .RN    (RN),
    .start (start),
    .cap_en(cap_en),
    .abort (abort),
    .pat   (pat),
    .SO    (SO),
    .SE    (SE),
    .SI    (SI),
    .busy  (busy),
    .done  (done),
    .resp  (resp)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Scan chain: shift towards flop N-1 when SE, else capture functional D.
  always @(posedge CK) begin
    if (SE) chain_q <= {chain_q[N-2:0], SI};
    else    chain_q <= chain_d;
  end
  assign SO = chain_q[N-1];

  task automatic chk_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] bitrev(input logic [N-1:0] v);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = v[N-1-i];
    return r;
  endfunction

  function automatic logic [N-1:0] rand_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // One complete operation, checked against latency, SI stream, SE count, resp.
  task automatic run_op(input logic [N-1:0] p, input logic c, input logic [N-1:0] d, input string tag);
    int           se_cnt;
    int           done_at;
    logic [N-1:0] si_seq;
    logic [N-1:0] exp_resp;
    int           exp_lat;
    exp_resp = c ? bitrev(d) : p;
    exp_lat  = c ? 2 * N + 2 : 2 * N + 1;
    se_cnt   = 0;
    done_at  = -1;
    si_seq   = '0;
    @(negedge CK);
    start   = 1'b1;
    abort   = 1'b0;
    pat     = p;
    cap_en  = c;
    chain_d = d;
    for (int cyc = 1; cyc <= 4 * N + 8 && done_at < 0; cyc++) begin
      @(negedge CK);
      start = 1'b0;
      if (SE) se_cnt++;
      if (cyc <= N) si_seq[cyc-1] = SI;
      if (done) done_at = cyc;
    end
    chk_val({tag, "_latency"}, done_at, exp_lat);
    chk_val({tag, "_resp"}, resp, exp_resp);
    chk_val({tag, "_se_cycles"}, se_cnt, 2 * N);
    chk_val({tag, "_si_seq"}, si_seq, p);
    @(negedge CK);
    chk_val({tag, "_done_1cyc"}, {done, busy}, 2'b00);
  endtask

  initial begin
    logic [N-1:0] p;
    logic [N-1:0] d;
    logic [N-1:0] prev_resp;
    int           dones;
    int           t[3];
    int           bad_done;

    checks  = 0;
    errors  = 0;
    RN      = 1'b0;
    start   = 1'b0;
    cap_en  = 1'b0;
    abort   = 1'b0;
    pat     = '0;
    chain_d = '0;

    // Reset state.
    repeat (3) @(negedge CK);
    chk_val("rst_se", SE, 1'b0);
    chk_val("rst_si", SI, 1'b0);
    chk_val("rst_busy", busy, 1'b0);
    chk_val("rst_done", done, 1'b0);
    chk_val("rst_resp", resp, '0);
    RN = 1'b1;
    @(negedge CK);

    // Directed loopback and capture.
    run_op(16'hB2D1, 1'b0, 16'h0000, "loop_dir");
    run_op(16'h0000, 1'b1, 16'h0033, "cap_dir");
    run_op(16'hFFFF, 1'b1, 16'h8001, "cap_edge");

    // Abort in UNLOAD cycle 2 of a loopback run.
    prev_resp = resp;
    @(negedge CK);
    start  = 1'b1;
    pat    = 16'h5A5A;
    cap_en = 1'b0;
    for (int cyc = 1; cyc <= N + 3; cyc++) begin
      @(negedge CK);
      start = 1'b0;
    end
    chk_val("abort_busy_pre", busy, 1'b1);
    abort = 1'b1;
    @(negedge CK);
    abort = 1'b0;
    chk_val("abort_busy", busy, 1'b0);
    chk_val("abort_se_si", {SE, SI}, 2'b00);
    chk_val("abort_resp", resp, prev_resp);
    bad_done = 0;
    repeat (2 * N) begin
      @(negedge CK);
      if (done) bad_done++;
    end
    chk_val("abort_no_done", bad_done, 0);
    run_op(16'h5A5A, 1'b0, 16'h0000, "after_abort");

    // start and abort together in IDLE: start dropped.
    @(negedge CK);
    start = 1'b1;
    abort = 1'b1;
    @(negedge CK);
    start = 1'b0;
    abort = 1'b0;
    chk_val("idle_abort_busy", busy, 1'b0);
    @(negedge CK);
    chk_val("idle_abort_busy2", {busy, SE}, 2'b00);

    // start held high: one run per IDLE visit, done pulses 2N+3 apart.
    d = rand_vec();
    @(negedge CK);
    start   = 1'b1;
    cap_en  = 1'b1;
    pat     = rand_vec();
    chain_d = d;
    dones   = 0;
    for (int cyc = 1; cyc <= 3 * (2 * N + 3) + 10 && dones < 3; cyc++) begin
      @(negedge CK);
      if (done) begin
        t[dones] = cyc;
        dones++;
      end
    end
    start = 1'b0;
    chk_val("held_dones", dones, 3);
    chk_val("held_first", t[0], 2 * N + 2);
    chk_val("held_gap1", t[1] - t[0], 2 * N + 3);
    chk_val("held_gap2", t[2] - t[1], 2 * N + 3);
    chk_val("held_resp", resp, bitrev(d));
    repeat (2 * N + 4) @(negedge CK);

    // Asynchronous reset during LOAD.
    run_op(16'hC3A5, 1'b0, 16'h0000, "pre_rst");
    @(negedge CK);
    start  = 1'b1;
    pat    = 16'h7E81;
    cap_en = 1'b0;
    @(negedge CK);
    start = 1'b0;
    @(negedge CK);
    #2 RN = 1'b0;
    #1;
    chk_val("arst_se", SE, 1'b0);
    chk_val("arst_busy", busy, 1'b0);
    chk_val("arst_resp", resp, '0);
    chk_val("arst_done_si", {done, SI}, 2'b00);
    @(negedge CK);
    RN = 1'b1;
    run_op(16'h7E81, 1'b0, 16'h0000, "post_rst");

    // Random loopback runs.
    for (int r = 0; r < 100; r++) begin
      p = rand_vec();
      run_op(p, 1'b0, rand_vec(), "rand_loop");
    end

    // Random mixed runs.
    for (int r = 0; r < 20; r++) begin
      p = rand_vec();
      d = rand_vec();
      run_op(p, 1'($urandom_range(0, 1)), d, "rand_mix");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 16, meaning the number of scan flops in the controlled chain (legal range 2..256).
REQ-002 SHALL have port CK, input, 1 bit: the single clock, rising-edge active, shared with the scan chain.
REQ-003 SHALL have port RN, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1 bit: request for one scan operation, sampled only in IDLE.
REQ-005 SHALL have port cap_en, input, 1 bit: 1 = load/capture/unload; 0 = load/unload only (loopback); sampled with start.
REQ-006 SHALL have port abort, input, 1 bit: synchronous cancel of the current operation.
REQ-007 SHALL have port pat, input, CHAIN_LEN bits: stimulus pattern, sampled with start.
REQ-008 SHALL have port SO, input, 1 bit: Q of the last chain flop (position CHAIN_LEN-1).
REQ-009 SHALL have port SE, output, 1 bit: scan enable to all chain flops.
REQ-010 SHALL have port SI, output, 1 bit: scan input to chain flop 0.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-013 SHALL have port resp, output, CHAIN_LEN bits: unloaded response, valid from the done cycle until the next accepted start.

Function
REQ-014 SHALL implement the FSM states IDLE, LOAD, CAPTURE, UNLOAD and DONE; all outputs SHALL be registered (Moore).
REQ-015 IDLE: start=1 SHALL latch pat, cap_en and clear the bit counter; the next state SHALL be LOAD. start=0 SHALL hold IDLE.
REQ-016 LOAD SHALL last exactly CHAIN_LEN cycles (k=0..CHAIN_LEN-1), with SE=1 and SI=pat_latched[k] in cycle k.
REQ-017 After LOAD, the next state SHALL be CAPTURE if cap_en was latched as 1, otherwise UNLOAD.
REQ-018 CAPTURE SHALL last exactly 1 cycle with SE=0 and SI=0, so that the chain captures its functional D inputs on that edge.
REQ-019 UNLOAD SHALL last exactly CHAIN_LEN cycles with SE=1 and SI=0; in cycle k, SO SHALL be sampled at the closing CK edge into resp[k].
REQ-020 DONE SHALL last 1 cycle with done=1 and SE=0, then return to IDLE; start in the DONE cycle SHALL be ignored.
REQ-021 Latency from the accepting start edge to done high: 2*CHAIN_LEN+2 cycles when cap_en=1, and 2*CHAIN_LEN+1 cycles when cap_en=0.
REQ-022 start while busy=1 SHALL be ignored, with no queueing.
REQ-023 abort=1 in any non-IDLE state SHALL force IDLE at the next edge with SE=0 and SI=0; done SHALL NOT pulse, and resp SHALL keep its previous value (partial bits discarded).
REQ-024 abort=1 in IDLE SHALL have no effect; if start and abort are both high in IDLE, abort SHALL win and the start SHALL be dropped.
REQ-025 The bit counter SHALL be $clog2(CHAIN_LEN) bits wide and reset to 0 on each LOAD and UNLOAD entry; the terminal count SHALL be CHAIN_LEN-1, with no wrap beyond it.
REQ-026 resp bits SHALL be written into a shadow register during UNLOAD and transferred to resp only on entry to DONE.

Reset
REQ-027 RN=0 SHALL immediately force state=IDLE, SE=0, SI=0, busy=0, done=0, resp=0, counter=0, and the latched pat/cap_en registers to 0.
REQ-028 RN asserted mid-operation SHALL abandon the operation with no done pulse; after RN rises, the first start SHALL be honoured normally.

Verification
REQ-029 CHAIN_LEN=4 with a bench SDFF chain model, pat=4'b1011, cap_en=0 -> SI sequence 1,1,0,1, then done at cycle 9 after start, resp=4'b1011.
REQ-030 CHAIN_LEN=4, chain D[3:0]=4'b0011, cap_en=1, pat=4'b0000 -> SE=0 for exactly one cycle (cycle 5), done at cycle 10, resp=4'b1100.
REQ-031 abort pulsed in UNLOAD cycle 2 -> busy=0 the next cycle, no done pulse, resp unchanged from the prior run; a following start completes normally.
REQ-032 start held high continuously over 3 runs -> exactly one run per IDLE visit, and consecutive done pulses 2*CHAIN_LEN+3 cycles apart (cap_en=1).
REQ-033 RN driven low asynchronously (between edges) during LOAD -> SE, busy and resp read 0 before the next CK edge.
REQ-034 CHAIN_LEN=16, random pat, cap_en=0, for 100 runs -> resp==pat on every run, and the SE high-cycle count per run is 32.
